// File: rtl/fetch_queue_top.sv
// Fetch stage: PC generator feeding a DEPTH-entry prefetch queue toward decode.
// Execute-stage redirects flush the queue and restart fetch at a word-aligned target.

module fetch_queue_entry #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [ILEN-1:0] wr_instr,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] instr
);
    // Payload only; validity is tracked by the queue pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc    <= wr_pc;
            instr <= wr_instr;
        end
    end
endmodule

module fetch_queue_top #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [ILEN-1:0]          imem_rdata,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_target,
    input  logic                     deq_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_pc_plus4,
    output logic [ILEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [XLEN-1:0]                   fetch_pc;
    logic [PW-1:0]                     wr_ptr;
    logic [PW-1:0]                     rd_ptr;
    logic [OW-1:0]                     occ;
    logic                              full;
    logic                              enq;
    logic                              deq;
    logic [DEPTH-1:0]                  ent_wr;
    logic [DEPTH-1:0][XLEN-1:0]        ent_pc;
    logic [DEPTH-1:0][ILEN-1:0]        ent_instr;

    assign full      = (occ == OW'(DEPTH));
    assign imem_req  = ~full & ~redirect_valid;
    assign imem_addr = fetch_pc;
    assign enq       = imem_req & ~reset;

    assign out_valid    = (occ != '0);
    assign out_pc       = ent_pc[rd_ptr];
    assign out_instr    = ent_instr[rd_ptr];
    assign out_pc_plus4 = out_pc + XLEN'(4);
    assign occupancy    = occ;
    assign deq          = out_valid & deq_ready & ~redirect_valid & ~reset;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_ent
            assign ent_wr[i] = enq & (wr_ptr == PW'(i));
            fetch_queue_entry #(.XLEN(XLEN), .ILEN(ILEN)) u_ent (
                .clk      (clk),
                .wr_en    (ent_wr[i]),
                .wr_pc    (fetch_pc),
                .wr_instr (imem_rdata),
                .pc       (ent_pc[i]),
                .instr    (ent_instr[i])
            );
        end
    endgenerate

    // Reset beats redirect beats fetch/dequeue; a full queue stalls fetch even if
    // the head leaves this cycle (one bubble accepted to keep 'full' off the deq path).
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_target[XLEN-1:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (enq) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule
